// File: rtl/pkg_memoria.sv
// rtl/pkg_memoria.sv - shared types and constants for the instruction memory
package pkg_memoria;

    typedef enum logic {
        OCIOSO = 1'b0,
        RESP   = 1'b1
    } estado_t;

    localparam int BITS_PADRAO       = 8;
    localparam int DEPTH_PADRAO      = 128;
    localparam int WORD_BYTES_PADRAO = 4;

    // Substituted by the decode stage whenever resp_erro is set.
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/memoria_bytes.sv
// rtl/memoria_bytes.sv - byte array with one write port and word-wide async read taps
module memoria_bytes
    import pkg_memoria::*;
#(
    parameter int BITS       = BITS_PADRAO,
    parameter int DEPTH      = DEPTH_PADRAO,
    parameter int WORD_BYTES = WORD_BYTES_PADRAO,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wr_endr,
    input  logic [BITS-1:0]            wr_dado,
    input  logic [ADDR_W:0]            rd_endr,
    output logic [BITS*WORD_BYTES-1:0] rd_dado
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    logic [BITS-1:0] mem [DEPTH];
    logic [ADDR_W:0] idx;

    always_ff @(posedge clk) begin
        if (we && ({1'b0, wr_endr} < DEPTH_EXT)) begin
            mem[wr_endr] <= wr_dado;
        end
    end

    // Taps past the end read as zero; the top masks such fetches anyway.
    always_comb begin
        rd_dado = '0;
        idx     = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            idx = rd_endr + (ADDR_W+1)'(k);
            if (idx < DEPTH_EXT) begin
                rd_dado[BITS*k +: BITS] = mem[idx[ADDR_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/memoria_instrucao_sinc.sv
// rtl/memoria_instrucao_sinc.sv - registered instruction fetch memory with handshakes and loader port
module memoria_instrucao_sinc
    import pkg_memoria::*;
#(
    parameter int BITS       = BITS_PADRAO,
    parameter int DEPTH      = DEPTH_PADRAO,
    parameter int WORD_BYTES = WORD_BYTES_PADRAO,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_W-1:0]          req_endr,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [BITS*WORD_BYTES-1:0] resp_dado,
    output logic                       resp_erro,
    input  logic                       prog_we,
    input  logic [ADDR_W-1:0]          prog_endr,
    input  logic [BITS-1:0]            prog_dado
);

    generate
        if ((DEPTH % WORD_BYTES) != 0 || DEPTH < WORD_BYTES) begin : g_param_invalido
            $error("memoria_instrucao_sinc: DEPTH must be a nonzero multiple of WORD_BYTES");
        end
    endgenerate

    // One extra bit keeps endr + WORD_BYTES-1 and the limit from wrapping.
    localparam logic [ADDR_W:0] LIMITE  = (ADDR_W+1)'(DEPTH - WORD_BYTES);
    localparam logic [ADDR_W:0] PASSO_W = (ADDR_W+1)'(WORD_BYTES);

    estado_t                   estado_q, estado_d;
    logic [BITS*WORD_BYTES-1:0] dado_q;
    logic                      erro_q;
    logic [BITS*WORD_BYTES-1:0] palavra;
    logic [ADDR_W:0]           endr_ext;
    logic                      erro_req;
    logic                      aceita;
    logic                      escreve;

    assign endr_ext = {1'b0, req_endr};
    assign erro_req = ((endr_ext % PASSO_W) != '0) || (endr_ext > LIMITE);

    assign req_ready = !prog_we && ((estado_q == OCIOSO) || resp_ready);
    assign aceita    = req_valid && req_ready;
    // A write coinciding with reset is dropped.
    assign escreve   = prog_we && !rst;

    memoria_bytes #(
        .BITS       (BITS),
        .DEPTH      (DEPTH),
        .WORD_BYTES (WORD_BYTES),
        .ADDR_W     (ADDR_W)
    ) u_bytes (
        .clk     (clk),
        .we      (escreve),
        .wr_endr (prog_endr),
        .wr_dado (prog_dado),
        .rd_endr (endr_ext),
        .rd_dado (palavra)
    );

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO: begin
                if (aceita) begin
                    estado_d = RESP;
                end
            end
            RESP: begin
                if (aceita) begin
                    estado_d = RESP;
                end else if (resp_ready) begin
                    estado_d = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= OCIOSO;
            dado_q   <= '0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            if (aceita) begin
                erro_q <= erro_req;
                dado_q <= erro_req ? '0 : palavra;
            end
        end
    end

    assign resp_valid = (estado_q == RESP);
    assign resp_dado  = dado_q;
    assign resp_erro  = erro_q;

endmodule

// File: tb/tb_memoria_instrucao_sinc.sv
// tb/tb_memoria_instrucao_sinc.sv - directed bench with a behavioural fetch model
module tb_memoria_instrucao_sinc;

    localparam int BITS  = 8;
    localparam int DEPTH = 128;
    localparam int WB    = 4;
    localparam int AW    = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_endr;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_dado;
    logic          resp_erro;
    logic          prog_we;
    logic [AW-1:0] prog_endr;
    logic [7:0]    prog_dado;

    int total = 0;
    int bad   = 0;

    memoria_instrucao_sinc dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_endr   (req_endr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_dado  (resp_dado),
        .resp_erro  (resp_erro),
        .prog_we    (prog_we),
        .prog_endr  (prog_endr),
        .prog_dado  (prog_dado)
    );

    always #5 clk = ~clk;

    // Model: byte array plus one pending-response slot.
    logic [7:0]  m_mem [DEPTH];
    bit          m_known  = 1'b0;
    bit          m_valid  = 1'b0;
    logic [31:0] m_dado   = '0;
    bit          m_erro   = 1'b0;

    function automatic bit m_ready_now();
        return !prog_we && (!m_valid || resp_ready);
    endfunction

    always @(posedge clk) begin
        int  a;
        bit  e;
        bit  acc;
        if (rst) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            m_dado  = '0;
            m_erro  = 1'b0;
        end else begin
            acc = req_valid && m_ready_now();
            if (prog_we) m_mem[prog_endr] = prog_dado;
            if (acc) begin
                a = int'(req_endr);
                e = (a % WB != 0) || (a > DEPTH - WB);
                m_valid = 1'b1;
                m_erro  = e;
                m_dado  = e ? 32'h0 : {m_mem[a+3], m_mem[a+2], m_mem[a+1], m_mem[a]};
            end else if (m_valid && resp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nome, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_known && !rst) begin
            chk("model req_ready", {31'b0, req_ready}, {31'b0, m_ready_now()});
            chk("model resp_valid", {31'b0, resp_valid}, {31'b0, m_valid});
            chk("model resp_dado", resp_dado, m_dado);
            chk("model resp_erro", {31'b0, resp_erro}, {31'b0, m_erro});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input int a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_endr = AW'(a);
        prog_dado = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic fetch_one(input int a);
        req_valid = 1'b1;
        req_endr  = AW'(a);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] bytes_tab [16];
        int         addr_tab  [16];
        bytes_tab = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                      8'h55, 8'h66, 8'h77, 8'h88, 8'hde, 8'had, 8'hbe, 8'hef};
        addr_tab  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 124, 125, 126, 127};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_endr   = '0;
        resp_ready = 1'b1;
        prog_we    = 1'b0;
        prog_endr  = '0;
        prog_dado  = '0;
        tick();
        tick();
        @(negedge clk);
        chk("reset resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("reset resp_dado", resp_dado, 32'h0);
        chk("reset resp_erro", {31'b0, resp_erro}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: load program, single fetch
        for (int i = 0; i < 16; i++) prog(addr_tab[i], bytes_tab[i]);
        fetch_one(0);
        chk("t1 resp_valid", {31'b0, resp_valid}, 32'h1);
        chk("t1 resp_dado", resp_dado, 32'h00500013);
        chk("t1 resp_erro", {31'b0, resp_erro}, 32'h0);
        tick();

        // 2: back-to-back at full throughput
        begin
            logic [31:0] exp_w [3];
            exp_w = '{32'h00500013, 32'h44332211, 32'h88776655};
            req_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                req_endr = AW'(4 * i);
                tick();
                if (i == 2) req_valid = 1'b0;
                @(negedge clk);
                chk("t2 resp_valid", {31'b0, resp_valid}, 32'h1);
                chk("t2 resp_dado", resp_dado, exp_w[i]);
                chk("t2 req_ready", {31'b0, req_ready}, 32'h1);
            end
            tick();
        end

        // 3: backpressure holds the response
        resp_ready = 1'b0;
        fetch_one(4);
        for (int i = 0; i < 3; i++) begin
            chk("t3 hold dado", resp_dado, 32'h44332211);
            chk("t3 hold req_ready", {31'b0, req_ready}, 32'h0);
            @(posedge clk);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("t3 drop valid", {31'b0, resp_valid}, 32'h0);
        chk("t3 dado held", resp_dado, 32'h44332211);

        // 4: error cases
        fetch_one(2);
        chk("t4 misaligned erro", {31'b0, resp_erro}, 32'h1);
        chk("t4 misaligned dado", resp_dado, 32'h0);
        fetch_one(126);
        chk("t4 range erro", {31'b0, resp_erro}, 32'h1);
        fetch_one(124);
        chk("t4 last word erro", {31'b0, resp_erro}, 32'h0);
        chk("t4 last word dado", resp_dado, 32'hefbeadde);
        tick();

        // 5: loader has priority over a fetch
        prog_we   = 1'b1;
        prog_endr = 7'd5;
        prog_dado = 8'hAA;
        req_valid = 1'b1;
        req_endr  = 7'd4;
        @(negedge clk);
        chk("t5 req_ready in write", {31'b0, req_ready}, 32'h0);
        tick();
        prog_we = 1'b0;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("t5 new byte", resp_dado, 32'h4433AA11);
        tick();

        // 6: reset drops a stalled response, memory survives, reset-cycle write ignored
        resp_ready = 1'b0;
        fetch_one(0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        prog_we   = 1'b1;
        prog_endr = 7'd0;
        prog_dado = 8'hFF;
        tick();
        rst     = 1'b0;
        prog_we = 1'b0;
        @(negedge clk);
        chk("t6 valid after rst", {31'b0, resp_valid}, 32'h0);
        chk("t6 dado after rst", resp_dado, 32'h0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        fetch_one(0);
        chk("t6 refetch", resp_dado, 32'h00500013);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
